// File: rtl/dance_scorer_multi.sv
// Multi-player colour-match scorer: per-player windowed match counting, round evaluation
// against a threshold, and streak-weighted saturating score accumulation.
module dance_scorer_multi #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned COUNT_W     = 20,
  parameter int unsigned SCORE_W     = 32,
  parameter int unsigned THRESHOLD   = 3,
  parameter int unsigned TOL         = 1,
  parameter int unsigned MAX_STREAK  = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [12*NUM_PLAYERS-1:0]      pixel_i,
  input  logic                           pixel_valid_i,
  input  logic [11:0]                    target_color_i,
  input  logic                           counting_i,
  input  logic                           update_i,
  output logic [SCORE_W*NUM_PLAYERS-1:0] score_o,
  output logic [4*NUM_PLAYERS-1:0]       streak_o,
  output logic [NUM_PLAYERS-1:0]         round_hit_o,
  output logic                           score_valid_o
);

  localparam int unsigned StreakCap = (MAX_STREAK > 15) ? 15 : MAX_STREAK;
  localparam logic [COUNT_W-1:0] CountMax = '1;

  typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

  state_e state_q, state_d;

  logic [NUM_PLAYERS-1:0]              match_d, match_q;
  logic                                upd_prev_q, upd_rise_q;
  logic [NUM_PLAYERS-1:0][COUNT_W-1:0] count_q, count_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_q, score_d;
  logic [NUM_PLAYERS-1:0][3:0]         streak_q, streak_d;
  logic [NUM_PLAYERS-1:0]              hit_q, hit_d;

  // Unsigned magnitude difference of one 4-bit component, no wrap-around.
  function automatic logic comp_ok(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return diff <= 4'(TOL);
  endfunction

  always_comb begin
    match_d = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      match_d[i] = pixel_valid_i & counting_i
                 & comp_ok(pixel_i[12*i+8 +: 4], target_color_i[11:8])
                 & comp_ok(pixel_i[12*i+4 +: 4], target_color_i[7:4])
                 & comp_ok(pixel_i[12*i   +: 4], target_color_i[3:0]);
    end
  end

  always_comb begin
    logic [COUNT_W:0] cnt_sum;
    logic [4:0]       pts;
    logic [SCORE_W:0] score_sum;
    logic             hit;

    state_d   = state_q;
    count_d   = count_q;
    score_d   = score_q;
    streak_d  = streak_q;
    hit_d     = hit_q;
    cnt_sum   = '0;
    pts       = '0;
    score_sum = '0;
    hit       = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        // In DONE, arriving matches already belong to the next round.
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (match_q[i] && (count_q[i] != CountMax)) count_d[i] = count_q[i] + 1'b1;
        end
        if (state_q == StDone)  state_d = StIdle;
        else if (upd_rise_q)    state_d = StEval;
      end
      StEval: begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          cnt_sum = {1'b0, count_q[i]} + (COUNT_W+1)'(match_q[i]);
          hit     = cnt_sum >= (COUNT_W+1)'(THRESHOLD);
          pts     = (streak_q[i] > 4'(StreakCap)) ? 5'(StreakCap + 1)
                                                  : {1'b0, streak_q[i]} + 5'd1;
          score_sum = {1'b0, score_q[i]} + (SCORE_W+1)'(pts);
          if (hit) begin
            score_d[i]  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            streak_d[i] = (streak_q[i] == 4'hF) ? 4'hF : streak_q[i] + 4'd1;
          end else begin
            streak_d[i] = 4'd0;
          end
          hit_d[i]   = hit;
          count_d[i] = '0;
        end
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      match_q    <= '0;
      upd_prev_q <= 1'b0;
      upd_rise_q <= 1'b0;
      count_q    <= '0;
      score_q    <= '0;
      streak_q   <= '0;
      hit_q      <= '0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      upd_prev_q <= update_i;
      upd_rise_q <= update_i & ~upd_prev_q;
      count_q    <= count_d;
      score_q    <= score_d;
      streak_q   <= streak_d;
      hit_q      <= hit_d;
    end
  end

  assign score_o       = score_q;
  assign streak_o      = streak_q;
  assign round_hit_o   = hit_q;
  assign score_valid_o = (state_q == StDone);

endmodule

// File: tb/tb_dance_scorer_multi.sv
// Scoreboard bench for dance_scorer_multi: directed rounds push expected results, a monitor
// compares them whenever score_valid is seen.
module tb_dance_scorer_multi;

  localparam int unsigned NP = 2;
  localparam int unsigned SW = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [12*NP-1:0] pixel;
  logic            pixel_valid;
  logic [11:0]     target_color;
  logic            counting;
  logic            update;
  logic [SW*NP-1:0] score;
  logic [4*NP-1:0] streak;
  logic [NP-1:0]   round_hit;
  logic            score_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0][5:0] sc;
    logic [1:0][3:0] st;
    logic [1:0]      hit;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [11:0] M = 12'h0F0;  // matches target exactly
  localparam logic [11:0] X = 12'hFFF;  // far from target

  dance_scorer_multi #(
    .NUM_PLAYERS(NP), .COUNT_W(20), .SCORE_W(SW), .THRESHOLD(3), .TOL(1), .MAX_STREAK(7)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_i       (pixel),
    .pixel_valid_i (pixel_valid),
    .target_color_i(target_color),
    .counting_i    (counting),
    .update_i      (update),
    .score_o       (score),
    .streak_o      (streak),
    .round_hit_o   (round_hit),
    .score_valid_o (score_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int s0, input int s1, input int k0, input int k1,
                      input logic h0, input logic h1);
    exp_t e;
    e.sc[0] = 6'(s0); e.sc[1] = 6'(s1);
    e.st[0] = 4'(k0); e.st[1] = 4'(k1);
    e.hit   = {h1, h0};
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (score_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_score_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("score", 32'(score), 32'(e.sc));
        check("streak", 32'(streak), 32'(e.st));
        check("round_hit", 32'(round_hit), 32'(e.hit));
      end
    end
  end

  task automatic drive(input logic [11:0] p0, input logic [11:0] p1, input logic v,
                       input logic c);
    pixel = {p1, p0}; pixel_valid = v; counting = c;
    @(posedge clk); #1;
  endtask

  // Update for one cycle with the given pixels, then idle; checks score_valid timing.
  task automatic do_update(input logic [11:0] p0, input logic [11:0] p1, input logic v);
    pixel = {p1, p0}; pixel_valid = v; counting = 1'b1; update = 1'b1;
    @(posedge clk); #1;
    update = 1'b0; pixel_valid = 1'b0;
    @(posedge clk); #1;
    check("valid_T+2", 32'(score_valid), 32'd0);
    @(posedge clk); #1;
    check("valid_T+3", 32'(score_valid), 32'd1);
    @(posedge clk); #1;
    check("valid_T+4", 32'(score_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pixel_valid = 1'b0; update = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("rst_score", 32'(score), 32'd0);
    check("rst_streak", 32'(streak), 32'd0);
    check("rst_hit", 32'(round_hit), 32'd0);
    check("rst_valid", 32'(score_valid), 32'd0);
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int sat_sc[16] = '{3, 6, 10, 15, 21, 28, 36, 44, 52, 60, 63, 63, 63, 63, 63, 63};
    int hit_sc[5]  = '{1, 3, 6, 10, 15};
    int pulses;

    reset = 1'b1; pixel = '0; pixel_valid = 1'b0; target_color = 12'h0F0;
    counting = 1'b0; update = 1'b0;
    do_reset();

    // Single hit on player 0, tolerance 1 per component.
    drive(12'h0F0, X, 1'b1, 1'b1);
    drive(12'h1E1, X, 1'b1, 1'b1);
    drive(12'h0F1, X, 1'b1, 1'b1);
    drive(12'h0E0, X, 1'b1, 1'b1);
    push(1, 0, 1, 0, 1'b1, 1'b0);
    do_update(X, X, 1'b0);

    // Tolerance boundary, counting low and pixel_valid low all give misses.
    drive(12'h2F0, 12'h0F2, 1'b1, 1'b1);
    drive(X, 12'h0F2, 1'b1, 1'b1);
    drive(X, 12'h0F2, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) drive(X, X, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(M, M, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(M, M, 1'b0, 1'b1);
    push(1, 0, 0, 0, 1'b0, 1'b0);
    do_update(X, X, 1'b0);

    // Streak weighting; player 1 sits exactly one below threshold.
    do_reset();
    for (int r = 0; r < 5; r++) begin
      drive(M, M, 1'b1, 1'b1);
      drive(M, M, 1'b1, 1'b1);
      drive(M, X, 1'b1, 1'b1);
      push(hit_sc[r], 0, r + 1, 0, 1'b1, 1'b0);
      do_update(X, X, 1'b0);
    end
    drive(M, M, 1'b1, 1'b1);
    drive(M, M, 1'b1, 1'b1);
    drive(X, M, 1'b1, 1'b1);
    push(15, 1, 0, 1, 1'b0, 1'b1);
    do_update(X, X, 1'b0);
    drive(M, M, 1'b1, 1'b1);
    drive(M, M, 1'b1, 1'b1);
    drive(M, X, 1'b1, 1'b1);
    push(16, 1, 1, 0, 1'b1, 1'b0);
    do_update(X, X, 1'b0);

    // Two players; player 1's third match arrives in the update cycle.
    do_reset();
    drive(M, M, 1'b1, 1'b1);
    drive(M, M, 1'b1, 1'b1);
    drive(M, X, 1'b1, 1'b1);
    push(1, 1, 1, 1, 1'b1, 1'b1);
    do_update(X, M, 1'b1);

    // Score saturation at 63 and streak cap at 15.
    for (int k = 2; k <= 17; k++) begin
      for (int i = 0; i < 3; i++) drive(M, M, 1'b1, 1'b1);
      push(sat_sc[k-2], sat_sc[k-2], (k < 15) ? k : 15, (k < 15) ? k : 15, 1'b1, 1'b1);
      do_update(X, X, 1'b0);
    end

    // Reset mid-round discards the partial count.
    drive(M, M, 1'b1, 1'b1);
    drive(M, M, 1'b1, 1'b1);
    do_reset();
    drive(M, M, 1'b1, 1'b1);
    push(0, 0, 0, 0, 1'b0, 1'b0);
    do_update(X, X, 1'b0);

    // Update held high is a single event.
    push(0, 0, 0, 0, 1'b0, 1'b0);
    pulses = 0;
    pixel_valid = 1'b0; update = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 10) update = 1'b0;
      @(posedge clk); #1;
      if (score_valid) pulses++;
    end
    check("held_update_pulses", 32'(pulses), 32'd1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule

// File: doc/dance_scorer_multi.md
Name: dance_scorer_multi

Overview:
- Multi-player successor to the single-channel scoring block. Per player, counts pixels matching a programmable target colour inside a counting window. At each round boundary (update), the count is compared against a threshold to decide hit/miss.
- Awards streak-weighted points and keeps a running saturating score per player.
- Sits between the per-player pixel pipelines (camera/pose overlay) and the score display/HUD logic.

Parameters:
- NUM_PLAYERS, 2, number of independent scoring channels (1..8)
- COUNT_W, 20, width of per-round match counter (saturating)
- SCORE_W, 32, width of each player's accumulated score (saturating)
- THRESHOLD, 3, minimum matches in a round for a hit
- TOL, 1, per-4-bit-component absolute colour tolerance (0..15)
- MAX_STREAK, 7, streak cap; points per hit = 1 + min(streak_before_hit, MAX_STREAK)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pixel  in  12*NUM_PLAYERS  packed RGB444 per player; player i at [12*i+11:12*i]
- pixel_valid  in  1  current pixel bus carries valid pixels
- target_color  in  12  RGB444 target; sampled every cycle
- counting  in  1  counting window open
- update  in  1  round-end pulse (any length; rising edge acts)
- score  out  SCORE_W*NUM_PLAYERS  accumulated score per player
- streak  out  4*NUM_PLAYERS  current consecutive-hit streak per player, capped at 15
- round_hit  out  NUM_PLAYERS  hit/miss result of last evaluated round
- score_valid  out  1  one-cycle pulse when score/streak/round_hit are refreshed

Behaviour:
- Reset (synchronous, active-high): all counters, score, streak, round_hit, score_valid, pipeline registers = 0; FSM -> IDLE. Reset mid-round discards the partial count. Reset has priority over every other input.
- Stage 1 (registered): match_i = pixel_valid & counting & (|R-Rt|<=TOL) & (|G-Gt|<=TOL) & (|B-Bt|<=TOL). Differences are unsigned 4-bit magnitudes; no wrap (0x0 vs 0xF differ by 15).
- Rising-edge detect of update is registered alongside stage 1, so the pixel presented in the update cycle is included in that round.
- FSM states:
  - IDLE: counter increments on match_d. Goes to EVAL on update_rise_d.
  - EVAL (1 cycle), per player:
    - hit = (count_i + match_d_i) >= THRESHOLD.
    - On hit: score_i += 1 + min(streak_i, MAX_STREAK), saturating at 2^SCORE_W-1; streak_i += 1, saturating at 15.
    - On miss: streak_i = 0.
    - round_hit_i = hit; count_i = 0.
    - Goes to DONE.
  - DONE (1 cycle): score_valid = 1; counter accumulates any match_d arriving this cycle (it belongs to the new round). Goes to IDLE.
- Latency: update rising at cycle T -> outputs updated at the end of T+2; score_valid high during T+3.
- An update rise during EVAL/DONE is dropped: one evaluation per rise, minimum round spacing of 3 cycles. update held high is a single event.
- Match counter saturates at 2^COUNT_W-1; it does not wrap.
- counting low: no increments, but update still evaluates (typically a miss, unless THRESHOLD=0). THRESHOLD=0 means every evaluated round is a hit.
- Changing target_color mid-round takes effect on the next pixel; no flush.
- Players are fully independent apart from the shared target_color, counting, update and pixel_valid.

Test Plan:
- Single hit (NUM_PLAYERS=1, THRESHOLD=3, TOL=1, target 0x0F0): 4 valid counting pixels 0x0F0, 0x1E1, 0x0F1, 0x0E0, then update -> score=1, streak=1, round_hit=1, score_valid pulses 3 cycles after update.
- Tolerance boundary: pixels 0x2F0 (R diff 2) and 0xFFF x10, then update -> count 0, miss, score unchanged, streak=0.
- Streak weighting: 5 consecutive hit rounds -> score 1,3,6,10,15; a miss round then gives streak=0 and score=15; the next hit gives score=16.
- Two players: player0 gets 3 matches, player1 gets 2, with the 3rd match of player1 arriving in the update cycle -> both hit (update-cycle pixel counted), both score=1.
- Saturation (SCORE_W=4): repeated hits until the score would exceed 15 -> score holds at 15; streak caps at 15.
- Reset mid-round after 2 matches, then 1 match, then update -> miss, score=0. An update held high for 10 cycles causes exactly one score_valid pulse.
